// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU core: the core pipeline state encoding and
// the bit positions of the {N,Z,P} condition-code fields.
package gpu_pkg;

  // Core pipeline states, driven by the core scheduler into each unit.
  typedef enum logic [2:0] {
    CS_IDLE    = 3'b000,
    CS_FETCH   = 3'b001,
    CS_DECODE  = 3'b010,
    CS_REQUEST = 3'b011,
    CS_WAIT    = 3'b100,
    CS_EXECUTE = 3'b101,
    CS_UPDATE  = 3'b110,
    CS_DONE    = 3'b111
  } core_state_t;

  // Raw encodings, for units that take core_state as a plain 3-bit vector.
  localparam logic [2:0] STATE_IDLE    = 3'b000;
  localparam logic [2:0] STATE_FETCH   = 3'b001;
  localparam logic [2:0] STATE_DECODE  = 3'b010;
  localparam logic [2:0] STATE_REQUEST = 3'b011;
  localparam logic [2:0] STATE_WAIT    = 3'b100;
  localparam logic [2:0] STATE_EXECUTE = 3'b101;
  localparam logic [2:0] STATE_UPDATE  = 3'b110;
  localparam logic [2:0] STATE_DONE    = 3'b111;

  // Bit indices inside a 3-bit condition-code field.
  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;

  // A branch is taken when any held flag matches the instruction's mask.
  // A zero mask therefore never branches; an all-ones mask branches on any
  // non-zero flag set.
  function automatic logic branch_taken(input logic [2:0] nzp,
                                        input logic [2:0] mask);
    return |(nzp & mask);
  endfunction

endpackage

// File: rtl/pc.sv
// Program-counter unit: holds the NZP condition codes produced by compare
// instructions and computes the registered next PC during EXECUTE, either the
// branch target or the sequential successor.
//
// Timing: updated_pc is a pure register output, valid one cycle after the
// EXECUTE edge. The branch decision uses the flags held before that edge, so
// flags latched in UPDATE only influence the following EXECUTE.
module pc
  import gpu_pkg::*;
#(
  parameter int PC_BITS  = 8,
  parameter int NZP_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          core_state,
  input  logic                nzp_write_en,
  input  logic [NZP_BITS-1:0] alu_nzp,
  input  logic [NZP_BITS-1:0] inst_nzp,
  input  logic [PC_BITS-1:0]  current_pc,
  input  logic [PC_BITS-1:0]  immediate,
  output logic [PC_BITS-1:0]  updated_pc
);

  logic [PC_BITS-1:0]  updated_pc_q, updated_pc_d;
  logic [NZP_BITS-1:0] nzp_q, nzp_d;
  logic                take_branch;

  // Next-state selection: PC moves only in EXECUTE, flags only in UPDATE.
  always_comb begin
    updated_pc_d = updated_pc_q;
    nzp_d        = nzp_q;
    take_branch  = branch_taken(nzp_q, inst_nzp);
    if (core_state == STATE_EXECUTE) begin
      // Sequential successor wraps naturally at 2^PC_BITS.
      updated_pc_d = take_branch ? immediate : (current_pc + PC_BITS'(1));
    end
    if ((core_state == STATE_UPDATE) && nzp_write_en) begin
      nzp_d = alu_nzp;
    end
  end

  // State registers; reset wins over any core_state in the same cycle and
  // clears the flags so the first EXECUTE after reset cannot branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      updated_pc_q <= '0;
      nzp_q        <= '0;
    end else begin
      updated_pc_q <= updated_pc_d;
      nzp_q        <= nzp_d;
    end
  end

  assign updated_pc = updated_pc_q;

endmodule

// File: tb/tb_pc.sv
// Directed bench for the PC unit: a linear sequence of steps, each driving
// one cycle of inputs and checking the registered results just after the edge.
module tb_pc;

  localparam int PC_BITS = 8;

  logic               clk;
  logic               reset;
  logic [2:0]         core_state;
  logic               nzp_write_en;
  logic [2:0]         alu_nzp;
  logic [2:0]         inst_nzp;
  logic [PC_BITS-1:0] current_pc;
  logic [PC_BITS-1:0] immediate;
  logic [PC_BITS-1:0] updated_pc;

  int checks;
  int failures;

  pc #(.PC_BITS(PC_BITS), .NZP_BITS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .core_state   (core_state),
    .nzp_write_en (nzp_write_en),
    .alu_nzp      (alu_nzp),
    .inst_nzp     (inst_nzp),
    .current_pc   (current_pc),
    .immediate    (immediate),
    .updated_pc   (updated_pc)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic [2:0] st, input logic we,
                      input logic [2:0] alu, input logic [2:0] inst,
                      input logic [7:0] cur, input logic [7:0] imm);
    reset        = rst;
    core_state   = st;
    nzp_write_en = we;
    alu_nzp      = alu;
    inst_nzp     = inst;
    current_pc   = cur;
    immediate    = imm;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pc(input string tag, input logic [7:0] exp);
    checks++;
    assert (updated_pc === exp)
    else begin
      failures++;
      $error("FAIL %s: updated_pc observed=%0d expected=%0d", tag, updated_pc, exp);
    end
  endtask

  task automatic check_nzp(input string tag, input logic [2:0] exp);
    checks++;
    assert (dut.nzp_q === exp)
    else begin
      failures++;
      $error("FAIL %s: nzp observed=%b expected=%b", tag, dut.nzp_q, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Scenario 1: reset wins over UPDATE with write enable.
    step(1'b1, 3'b110, 1'b1, 3'b111, 3'b000, 8'd0, 8'd0);
    check_pc ("s1_reset_pc", 8'd0);
    check_nzp("s1_reset_nzp", 3'b000);

    // Scenario 2: zero mask never branches.
    step(1'b0, 3'b101, 1'b0, 3'b000, 3'b000, 8'd20, 8'd12);
    check_pc ("s2_mask0", 8'd21);
    // Full mask with cleared flags also falls through.
    step(1'b0, 3'b101, 1'b0, 3'b000, 3'b111, 8'd33, 8'd12);
    check_pc ("s2_mask7_nzp0", 8'd34);

    // Scenario 3: latch N, PC holds through UPDATE, then full mask branches.
    step(1'b0, 3'b110, 1'b1, 3'b100, 3'b111, 8'd90, 8'd91);
    check_nzp("s3_latch_n", 3'b100);
    check_pc ("s3_pc_hold_update", 8'd34);
    step(1'b0, 3'b101, 1'b0, 3'b000, 3'b111, 8'd20, 8'd12);
    check_pc ("s3_branch", 8'd12);

    // Scenario 4: mismatched mask falls through; disabled write holds flags.
    step(1'b0, 3'b101, 1'b0, 3'b000, 3'b010, 8'd20, 8'd12);
    check_pc ("s4_no_match", 8'd21);
    step(1'b0, 3'b110, 1'b0, 3'b001, 3'b000, 8'd20, 8'd12);
    check_nzp("s4_we0_hold", 3'b100);
    check_pc ("s4_pc_hold", 8'd21);
    step(1'b0, 3'b101, 1'b0, 3'b000, 3'b100, 8'd30, 8'd77);
    check_pc ("s4_match_n", 8'd77);

    // Flags written in a non-UPDATE state are ignored.
    step(1'b0, 3'b000, 1'b1, 3'b001, 3'b000, 8'd1, 8'd2);
    check_nzp("idle_we_ignored", 3'b100);
    check_pc ("idle_pc_hold", 8'd77);

    // EXECUTE ignores the write enable; branch uses pre-edge flags.
    step(1'b0, 3'b110, 1'b1, 3'b010, 3'b000, 8'd0, 8'd0);
    check_nzp("latch_z", 3'b010);
    step(1'b0, 3'b101, 1'b1, 3'b001, 3'b001, 8'd40, 8'd99);
    check_pc ("pre_edge_flags", 8'd41);
    check_nzp("exec_we_ignored", 3'b010);

    // Scenario 5: wrap at 255, then hold through FETCH and DECODE.
    step(1'b0, 3'b101, 1'b0, 3'b000, 3'b001, 8'd255, 8'd7);
    check_pc ("s5_wrap", 8'd0);
    step(1'b0, 3'b001, 1'b0, 3'b000, 3'b010, 8'd100, 8'd101);
    check_pc ("s5_fetch_hold", 8'd0);
    step(1'b0, 3'b010, 1'b0, 3'b000, 3'b010, 8'd110, 8'd111);
    check_pc ("s5_decode_hold", 8'd0);

    // Move PC off zero so the reset in scenario 6 is visible.
    step(1'b0, 3'b101, 1'b0, 3'b000, 3'b010, 8'd3, 8'd50);
    check_pc ("pre_s6_branch", 8'd50);

    // Scenario 6: reset with a would-be branching EXECUTE.
    step(1'b1, 3'b101, 1'b0, 3'b000, 3'b010, 8'd3, 8'd60);
    check_pc ("s6_reset_pc", 8'd0);
    check_nzp("s6_reset_nzp", 3'b000);

    // First EXECUTE after reset cannot branch.
    step(1'b0, 3'b101, 1'b0, 3'b000, 3'b111, 8'd5, 8'd9);
    check_pc ("post_reset_no_branch", 8'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
